// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream, built from two line buffers.
// Its nine outputs and win_valid feed the median sorter directly.
module window_gen_3x3 #(
   parameter int LINE_W = 16,
   parameter int PIX_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             pix_sof,
   output logic [PIX_W-1:0] x_0,
   output logic [PIX_W-1:0] x_1,
   output logic [PIX_W-1:0] x_2,
   output logic [PIX_W-1:0] x_3,
   output logic [PIX_W-1:0] x_4,
   output logic [PIX_W-1:0] x_5,
   output logic [PIX_W-1:0] x_6,
   output logic [PIX_W-1:0] x_7,
   output logic [PIX_W-1:0] x_8,
   output logic             win_valid
);

   localparam int            CW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);

   logic [CW-1:0]    col_q, col_d, col_eff;
   logic [1:0]       row_q, row_d, row_eff;
   logic             win_valid_q, win_valid_d;
   logic [PIX_W-1:0] win_q [9];
   logic [PIX_W-1:0] lb1_q [LINE_W];
   logic [PIX_W-1:0] lb2_q [LINE_W];
   logic [PIX_W-1:0] lb1_rd, lb2_rd;

   // A start-of-frame pixel is positioned at (0,0) regardless of the running counters.
   always_comb begin
      col_eff     = pix_sof ? '0 : col_q;
      row_eff     = pix_sof ? 2'd0 : row_q;
      lb1_rd      = lb1_q[col_eff];
      lb2_rd      = lb2_q[col_eff];
      col_d       = col_eff + CW'(1);
      row_d       = row_eff;
      if (col_eff == COL_LAST) begin
         col_d = '0;
         row_d = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
      end
      win_valid_d = pix_valid && (row_eff == 2'd2) && (col_eff >= CW'(2));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= 2'd0;
         win_valid_q <= 1'b0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
      end else begin
         win_valid_q <= win_valid_d;
         if (pix_valid) begin
            col_q    <= col_d;
            row_q    <= row_d;
            win_q[0] <= win_q[1];
            win_q[1] <= win_q[2];
            win_q[2] <= lb2_rd;
            win_q[3] <= win_q[4];
            win_q[4] <= win_q[5];
            win_q[5] <= lb1_rd;
            win_q[6] <= win_q[7];
            win_q[7] <= win_q[8];
            win_q[8] <= pix_in;
         end
      end
   end

   // Line buffers hold no reset; win_valid only rises once both lines are rewritten in-frame.
   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb2_q[col_eff] <= lb1_rd;
         lb1_q[col_eff] <= pix_in;
      end
   end

   assign x_0       = win_q[0];
   assign x_1       = win_q[1];
   assign x_2       = win_q[2];
   assign x_3       = win_q[3];
   assign x_4       = win_q[4];
   assign x_5       = win_q[5];
   assign x_6       = win_q[6];
   assign x_7       = win_q[7];
   assign x_8       = win_q[8];
   assign win_valid = win_valid_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 at LINE_W=4: directed frames plus random pixels and idle gaps,
// checked against a frame-indexed reference model.
module tb_window_gen_3x3;
   localparam int LW = 4;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [PW-1:0] pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          pix_sof = 1'b0;
   logic [PW-1:0] x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8;
   logic          win_valid;

   window_gen_3x3 #(.LINE_W(LW), .PIX_W(PW)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3), .x_4(x_4), .x_5(x_5), .x_6(x_6),
      .x_7(x_7), .x_8(x_8), .win_valid(win_valid)
   );

   always #5 clk = ~clk;

   logic [PW-1:0] xs [9];
   assign xs[0] = x_0;
   assign xs[1] = x_1;
   assign xs[2] = x_2;
   assign xs[3] = x_3;
   assign xs[4] = x_4;
   assign xs[5] = x_5;
   assign xs[6] = x_6;
   assign xs[7] = x_7;
   assign xs[8] = x_8;

   int            ntests = 0;
   int            nfail = 0;
   int            nvalid = 0;
   int            first_valid = -1;
   logic [PW-1:0] frame [$];
   logic [PW-1:0] h [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ntests++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Model: pixel n of the current frame sits at row n/LW, column n%LW; the window is
   // taken straight from the stored frame, and x_6..x_8 are the last three accepted pixels.
   task automatic check_outputs(input string tag, input bit accepted);
      int n;
      bit full;
      n    = frame.size() - 1;
      full = (frame.size() > 0) && (n >= 2 * LW) && ((n % LW) >= 2);
      chk({tag, ".win_valid"}, {31'd0, win_valid}, {31'd0, accepted && full});
      for (int k = 0; k < 3; k++)
         chk($sformatf("%s.x_%0d", tag, 6 + k), {24'd0, xs[6 + k]}, {24'd0, h[k]});
      if (full) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               chk($sformatf("%s.win_x_%0d", tag, i * 3 + j), {24'd0, xs[i * 3 + j]},
                   {24'd0, frame[n - (2 - i) * LW - (2 - j)]});
      end
      if (accepted && full) begin
         nvalid++;
         if (first_valid < 0) first_valid = n;
      end
   endtask

   task automatic send(input logic [PW-1:0] pix, input bit sof);
      @(negedge clk);
      pix_in = pix; pix_valid = 1'b1; pix_sof = sof;
      @(posedge clk);
      #1;
      if (sof) frame.delete();
      frame.push_back(pix);
      h[0] = h[1]; h[1] = h[2]; h[2] = pix;
      check_outputs($sformatf("pix%0d", pix), 1'b1);
   endtask

   task automatic idle(input bit sof_noise);
      @(negedge clk);
      pix_valid = 1'b0; pix_sof = sof_noise; pix_in = PW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check_outputs("idle", 1'b0);
   endtask

   task automatic chk_window(input string tag, input int e [9]);
      for (int i = 0; i < 9; i++)
         chk($sformatf("%s.x_%0d", tag, i), {24'd0, xs[i]}, e[i]);
      chk({tag, ".win_valid"}, {31'd0, win_valid}, 32'd1);
   endtask

   task automatic chk_reset_state(input string tag);
      for (int i = 0; i < 9; i++)
         chk($sformatf("%s.x_%0d", tag, i), {24'd0, xs[i]}, 32'd0);
      chk({tag, ".win_valid"}, {31'd0, win_valid}, 32'd0);
   endtask

   initial begin
      int w10 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      int w11 [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
      int w14 [9] = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
      int w110 [9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
      h = '{default: '0};

      // Power-on reset
      #2 rst = 1'b1;
      #1 chk_reset_state("por");
      @(negedge clk) rst = 1'b0;

      // Frame 0..15 back to back
      nvalid = 0; first_valid = -1;
      for (int v = 0; v <= 10; v++) send(PW'(v), v == 0);
      chk_window("v10", w10);
      send(8'd11, 1'b0);
      chk_window("v11", w11);
      send(8'd12, 1'b0);
      send(8'd13, 1'b0);
      send(8'd14, 1'b0);
      chk_window("v14", w14);
      send(8'd15, 1'b0);
      chk("first_valid", first_valid, 10);
      chk("nvalid_frame0", nvalid, 4);

      // Same frame with random idle gaps; sof toggles while idle and must be ignored
      nvalid = 0; first_valid = -1;
      for (int v = 0; v <= 15; v++) begin
         send(PW'(v), v == 0);
         if ($urandom_range(0, 1) == 1)
            repeat ($urandom_range(1, 3)) idle(1'($urandom_range(0, 1)));
      end
      chk("first_valid_gaps", first_valid, 10);
      chk("nvalid_gaps", nvalid, 4);

      // Asynchronous reset mid-frame, then a new frame without sof
      for (int v = 0; v <= 7; v++) send(PW'(v), v == 0);
      #3 rst = 1'b1;
      #1 chk_reset_state("async_rst");
      frame.delete();
      h = '{default: '0};
      @(negedge clk);
      pix_valid = 1'b1; pix_in = 8'd77; pix_sof = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_reset_state("rst_held");
      @(negedge clk);
      rst = 1'b0; pix_valid = 1'b0;
      nvalid = 0; first_valid = -1;
      for (int v = 100; v <= 110; v++) send(PW'(v), 1'b0);
      chk_window("v110", w110);
      for (int v = 111; v <= 115; v++) send(PW'(v), 1'b0);
      chk("first_valid_rst", first_valid, 10);
      chk("nvalid_rst", nvalid, 4);

      // Mid-stream sof on the 7th pixel restarts the frame
      for (int k = 0; k < 6; k++) send(PW'(200 + k), k == 0);
      first_valid = -1;
      for (int k = 6; k < 24; k++) send(PW'(200 + k), k == 6);
      chk("first_valid_midsof", first_valid, 10);

      // 40 random pixels, 10 lines
      nvalid = 0;
      for (int k = 0; k < 40; k++) send(PW'($urandom_range(0, 255)), k == 0);
      chk("nvalid_40", nvalid, 16);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter LINE_W, default 16, meaning pixels per image line (legal range 3..1024).
REQ-002 SHALL have parameter PIX_W, default 8, meaning bits per pixel.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pix_in  input  PIX_W  incoming raster-order pixel.
REQ-006 SHALL have port pix_valid  input  1  pix_in is accepted on a rising edge where pix_valid=1.
REQ-007 SHALL have port pix_sof  input  1  start of frame; qualified by pix_valid; marks the pixel at row 0, column 0.
REQ-008 SHALL have ports x_0..x_8  output  PIX_W each  3x3 window, row-major; x_0..x_2 oldest row, x_6..x_8 newest row, left to right.
REQ-009 SHALL have port win_valid  output  1  x_0..x_8 form a complete in-frame window.

Function
REQ-010 SHALL keep column counter col (0..LINE_W-1) and row counter row saturating at 2; both advance only on accepted pixels.
REQ-011 On an accepted pixel, col SHALL increment; at col=LINE_W-1 it SHALL wrap to 0 and row SHALL increment (saturating at 2).
REQ-012 An accepted pixel with pix_sof=1 SHALL be treated as row 0, column 0; the next accepted pixel is column 1 and the counters continue from there.
REQ-013 SHALL hold two line buffers of LINE_W entries each: lb1 holding the previous line, lb2 holding the line before that, addressed by col.
REQ-014 On an accepted pixel at (row r, column c), the window SHALL shift left by one column and load the new right column: x_8<=pix_in, x_5<=lb1[c], x_2<=lb2[c]; in the same cycle lb2[c]<=lb1[c] and lb1[c]<=pix_in.
REQ-015 After acceptance, x_6..x_8 SHALL equal pixels (r,c-2..c), x_3..x_5 SHALL equal (r-1,c-2..c), and x_0..x_2 SHALL equal (r-2,c-2..c).
REQ-016 Latency SHALL be exactly 1 cycle: win_valid SHALL be registered, going high on the edge that accepts a pixel with r>=2 and c>=2 (row and column values before that edge's update).
REQ-017 win_valid SHALL be low in any cycle following an edge with pix_valid=0; x_0..x_8 SHALL hold their values while no pixel is accepted.
REQ-018 Windows that straddle a line wrap (c=0 or c=1) SHALL assert win_valid=0; no border padding is generated.
REQ-019 pix_sof asserted mid-frame SHALL restart the counters, so win_valid stays low until the new frame reaches r>=2, c>=2; the window registers keep shifting normally.
REQ-020 pix_sof with pix_valid=0 SHALL be ignored.
REQ-021 Output x_0..x_8 SHALL be directly suitable as the 9 parallel inputs of the team's pipelined median sorter; win_valid is the companion qualifier.
REQ-022 The block SHALL have no backpressure input and SHALL accept one pixel per cycle with no bubbles required.

Reset
REQ-023 While rst=1: col=0, row=0, win_valid=0, and x_0..x_8=0, taking effect immediately without a clock edge.
REQ-024 Line buffer contents SHALL NOT be reset; stale contents SHALL never appear in a window with win_valid=1.
REQ-025 After rst deasserts, the first accepted pixel SHALL be treated as row 0, column 0 whether or not pix_sof=1.

Verification (LINE_W=4, PIX_W=8)
REQ-026 Feed values 0..15 back-to-back, with sof on value 0 -> win_valid first high after value 10, with x_0..x_8=0,1,2,4,5,6,8,9,10; after value 11, x_0..x_8=1,2,3,5,6,7,9,10,11.
REQ-027 Continuing the same stream: after value 12 and after value 13, win_valid=0; after value 14, x_0..x_8=4,5,6,8,9,10,12,13,14 with win_valid=1.
REQ-028 Same stream with 1-3 idle cycles inserted randomly -> identical window sequence; win_valid=0 in every cycle after an idle edge; outputs held.
REQ-029 Assert rst asynchronously after value 7, release, and feed a new frame 100..115 -> outputs are 0 during rst; the first window comes after value 110 and equals 100,101,102,104,105,106,108,109,110.
REQ-030 Assert pix_sof on value 6 of a running stream -> win_valid stays low until the 11th pixel counted from the sof pixel.
REQ-031 Stream 40 pixels continuously (10 lines) -> exactly 2 valid windows per line from line 2 onward (16 total), each matching a reference model.
